// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the RV32I pipeline hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_REG         = 2'b00;
  localparam logic [1:0] FWD_WB          = 2'b01;
  localparam logic [1:0] FWD_MEM         = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // x0 is hard-wired zero, so a match on it is never a real dependency.
  function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd);
    return (rs != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Execute operand source select for one operand; Memory beats Writeback.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_REG;
    if (reg_write_m && reg_match(rs_e, rd_m)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && reg_match(rs_e, rd_w)) begin
      fwd = FWD_WB;
    end else begin
      fwd = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control for the 5-stage RV32I core with memory-wait FSM.
// HAZARD_FWD_EN selects operand forwarding; otherwise RAW hazards stall Decode.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             Rs1D,
  input  logic [4:0]             Rs2D,
  input  logic [4:0]             Rs1E,
  input  logic [4:0]             Rs2E,
  input  logic [4:0]             RdE,
  input  logic                   RegWriteE,
  input  logic [1:0]             ResultSrcE,
  input  logic                   PCSrcE,
  input  logic [4:0]             RdM,
  input  logic                   RegWriteM,
  input  logic [4:0]             RdW,
  input  logic                   RegWriteW,
  input  logic                   MemReqM,
  input  logic                   MemReadyM,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   StallE,
  output logic                   StallM,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   FlushW,
  output logic [1:0]             ForwardAE,
  output logic [1:0]             ForwardBE,
  output logic                   MemErr,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(MEM_TIMEOUT);
  localparam logic [STALL_CNT_W-1:0] SC_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  hz_state_t              state_q, state_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   mem_err_q, mem_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             mem_wait_s;
  logic             hold_s;
  logic             load_use_s;
  logic             stall_req_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [1:0]       fwd_a_s, fwd_b_s;

  assign mem_wait_s = MemReqM && !MemReadyM;
  assign hold_s     = (state_q == ERROR) || mem_wait_s;
  assign load_use_s = (ResultSrcE == RESULT_SRC_LOAD) &&
                      (reg_match(Rs1D, RdE) || reg_match(Rs2D, RdE));

`ifdef HAZARD_FWD_EN
  forward_sel u_fwd_a (
    .rs_e(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_a_s)
  );
  forward_sel u_fwd_b (
    .rs_e(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_b_s)
  );
  assign stall_req_s = load_use_s;
`else
  // Writeback needs no stall: the register file writes on the falling edge.
  logic unused_fwd_s;
  assign unused_fwd_s = ^{Rs1E, Rs2E, RdW, RegWriteW};
  assign fwd_a_s      = FWD_REG;
  assign fwd_b_s      = FWD_REG;
  assign stall_req_s  = load_use_s ||
                        (RegWriteE && (reg_match(Rs1D, RdE) || reg_match(Rs2D, RdE))) ||
                        (RegWriteM && (reg_match(Rs1D, RdM) || reg_match(Rs2D, RdM)));
`endif

  assign cnt_next_s = wait_cnt_q + CNT_ONE;

  // Memory wait FSM: a ready in the timeout cycle still releases to RUN.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_wait_s) begin
          if (cnt_next_s >= CNT_TMO) begin
            state_d    = ERROR;
            wait_cnt_d = '0;
            mem_err_d  = 1'b1;
          end else begin
            state_d    = MEM_WAIT;
            wait_cnt_d = cnt_next_s;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      ERROR: begin
        state_d   = ERROR;
        mem_err_d = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Pipeline controls; reset forces bubbles into D, E and W.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (hold_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (stall_req_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      FlushE = 1'b0;
    end
  end

  assign ForwardAE = rst_n ? fwd_a_s : FWD_REG;
  assign ForwardBE = rst_n ? fwd_b_s : FWD_REG;

  // Saturating count of fetch-stall cycles.
  always_comb begin
    if (StallF && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + SC_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a behavioural model.
module tb_hazard_unit;

  localparam int TMO  = 4;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]    ResultSrcE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] StallCount;

  int checks = 0;
  int errors = 0;

  // Model: consecutive stalled wait cycles, error flag, stall count.
  int m_waited;
  bit m_err;
  int m_cnt;

  hazard_unit #(.MEM_TIMEOUT(TMO), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
`ifdef HAZARD_FWD_EN
    if (RegWriteM && rs != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && rs != 5'd0 && RdW == rs) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic bit dep_on(input logic [4:0] rs);
    bit d;
    d = (rs != 5'd0) && (ResultSrcE == 2'b01) && (RdE == rs);
`ifndef HAZARD_FWD_EN
    d = d || ((rs != 5'd0) && RegWriteE && RdE == rs);
    d = d || ((rs != 5'd0) && RegWriteM && RdM == rs);
`endif
    return d;
  endfunction

  task automatic eval_cycle();
    bit wait_now, hold, dep;
    bit e_sfd, e_fd, e_fe, e_fw;
    if (!rst_n) begin
      m_waited = 0;
      m_err    = 0;
      m_cnt    = 0;
    end
    wait_now = MemReqM && !MemReadyM;
    hold     = rst_n && (m_err || wait_now);
    dep      = dep_on(Rs1D) || dep_on(Rs2D);
    e_sfd    = rst_n && (hold || (!PCSrcE && dep));
    e_fd     = !rst_n || (!hold && PCSrcE);
    e_fe     = !rst_n || (!hold && (PCSrcE || dep));
    e_fw     = !rst_n || hold;
    chk("StallF", 64'(StallF), 64'(e_sfd));
    chk("StallD", 64'(StallD), 64'(e_sfd));
    chk("StallE", 64'(StallE), 64'(hold));
    chk("StallM", 64'(StallM), 64'(hold));
    chk("FlushD", 64'(FlushD), 64'(e_fd));
    chk("FlushE", 64'(FlushE), 64'(e_fe));
    chk("FlushW", 64'(FlushW), 64'(e_fw));
    chk("ForwardAE", 64'(ForwardAE), 64'(rst_n ? fwd_of(Rs1E) : 2'b00));
    chk("ForwardBE", 64'(ForwardBE), 64'(rst_n ? fwd_of(Rs2E) : 2'b00));
    chk("MemErr", 64'(MemErr), 64'(m_err));
    chk("StallCount", 64'(StallCount), 64'(m_cnt));
    if (rst_n) begin
      if (e_sfd && m_cnt < CMAX) m_cnt++;
      if (!m_err) begin
        if (wait_now) begin
          m_waited++;
          if (m_waited >= TMO) m_err = 1;
        end else begin
          m_waited = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic randomize_inputs();
    Rs1D = 5'($urandom_range(3, 0)); Rs2D = 5'($urandom_range(3, 0));
    Rs1E = 5'($urandom_range(3, 0)); Rs2E = 5'($urandom_range(3, 0));
    RdE  = 5'($urandom_range(3, 0)); RdM  = 5'($urandom_range(3, 0));
    RdW  = 5'($urandom_range(3, 0));
    RegWriteE = 1'($urandom_range(1, 0));
    RegWriteM = 1'($urandom_range(1, 0));
    RegWriteW = 1'($urandom_range(1, 0));
    ResultSrcE = 2'($urandom_range(3, 0));
    PCSrcE    = ($urandom_range(9, 0) == 0);
    MemReqM   = ($urandom_range(3, 0) == 0);
    MemReadyM = ($urandom_range(9, 0) < 7);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Forwarding: Memory and Writeback both match Rs1E.
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1'b1; Rs2E = 5'd6;
    step();
    Rs1E = 5'd0; RdM = 5'd0; Rs2E = 5'd5;
    step();
    clear_inputs();

    // Load-use on Rs2D, then a clean cycle.
    ResultSrcE = 2'b01; RdE = 5'd7; RegWriteE = 1'b1; Rs2D = 5'd7;
    step();
    clear_inputs();
    step();

    // Load-use coincident with a taken branch.
    ResultSrcE = 2'b01; RdE = 5'd7; RegWriteE = 1'b1; Rs1D = 5'd7; PCSrcE = 1'b1;
    step();
    clear_inputs();

    // Three wait cycles then ready; a branch during the wait is suppressed.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    step();
    PCSrcE = 1'b1;
    step();
    PCSrcE = 1'b0;
    step();
    MemReadyM = 1'b1;
    step();
    clear_inputs();
    step();

    // RAW on Rs1D with RdE, and x0 never stalls.
    RdE = 5'd3; RegWriteE = 1'b1; Rs1D = 5'd3;
    step();
    RdE = 5'd0; Rs1D = 5'd0;
    step();
    clear_inputs();

    // Timeout into ERROR, then reset out of it.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < TMO + 3; i++) step();
    clear_inputs();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Ready arriving in the timeout cycle releases to RUN.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < TMO - 1; i++) step();
    MemReadyM = 1'b1;
    step();
    clear_inputs();
    step();

    // Randomized traffic without reset, long enough to saturate StallCount.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end
    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      rst_n = ($urandom_range(29, 0) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage RV32I core.
- Consumes the register and control fields that pipeline registers deliver to Execute, Memory and Writeback.
- Drives back the stall, flush and forwarding controls those registers and the Execute operand muxes obey.
- Contains the data-memory wait/timeout FSM and a stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16: consecutive unanswered memory-wait cycles before the error freeze.
- STALL_CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
- Rs1E, Rs2E  in  5 each  source registers in Execute.
- RdE  in  5  destination in Execute.
- RegWriteE  in  1  Execute writes the register file.
- ResultSrcE  in  2  Execute result select; 2'b01 = load.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- RdM, RegWriteM  in  5 / 1  Memory-stage destination and write enable.
- RdW, RegWriteW  in  5 / 1  Writeback-stage destination and write enable.
- MemReqM  in  1  load/store active in Memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1 each  clear the corresponding pipeline register to a bubble.
- ForwardAE, ForwardBE  out  2 each  Execute operand source: 00 = regfile, 01 = Writeback result, 10 = ALUResultM.
- MemErr  out  1  sticky memory-timeout error.
- StallCount  out  STALL_CNT_W  cycles with StallF=1, saturating.

Behaviour:
- Reset (rst_n=0, async):
  - state=RUN, WaitCnt=0, MemErr=0, StallCount=0.
  - All Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
  - Reset mid-wait or in ERROR returns to RUN immediately.
- Forwarding (combinational, applied per operand):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E (or Rs2E).
  - else 01 if RegWriteW && RdW!=0 && RdW matches.
  - else 00.
  - Memory beats Writeback on a double match.
- Load-use (combinational, state RUN):
  - Condition: ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - Response: StallF=StallD=1, FlushE=1 for one cycle.
- Branch (combinational, state RUN): PCSrcE → FlushD=FlushE=1.
- Priority (highest first): memory wait > branch > load-use.
  - Branch coincident with load-use: StallF=StallD=0; the Decode instruction is flushed.
  - Branch during memory wait: flush suppressed; Execute is held, so the branch re-resolves on release.
- Memory wait (Mealy):
  - Trigger: any cycle with MemReqM=1 && MemReadyM=0.
  - Response: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0.
- FSM states RUN, MEM_WAIT, ERROR:
  - RUN → MEM_WAIT on the wait condition; WaitCnt<=1.
  - MEM_WAIT with MemReadyM=1: stalls drop the same cycle; → RUN.
  - MEM_WAIT with MemReadyM=0: WaitCnt++. If WaitCnt reaches MEM_TIMEOUT → ERROR.
  - Net effect: exactly MEM_TIMEOUT stalled cycles precede ERROR.
  - MemReadyM arriving in the same cycle as the timeout wins → RUN.
  - ERROR: MemErr=1 from the entry edge; StallF/D/E/M=1 and FlushW=1 permanently; left only by reset.
- StallCount: +1 on each edge where StallF=1; holds at all-ones; never wraps.
- x0: never forwarded, never causes a stall.

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined: forwarding as specified above.
- Undefined:
  - ForwardAE=ForwardBE=00 constant.
  - RAW stall replaces forwarding: if Rs1D or Rs2D (non-zero) equals RdE with RegWriteE, or RdM with RegWriteM, then StallF=StallD=1 and FlushE=1.
  - Writeback needs no stall because the register file writes on the falling edge.
  - The RAW stall has the same priority as load-use.

Decomposition:
- hazard_pkg holds:
  - enum hz_state_t {RUN, MEM_WAIT, ERROR}.
  - Constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, RESULT_SRC_LOAD=2'b01.
- Sub-module forward_sel: combinational source select for one operand, instantiated twice (A, B).

Test Plan:
- add x5 in M, RdM=5, RegWriteM=1, Rs1E=5; also RdW=5, RegWriteW=1 → ForwardAE=10, ForwardBE=00.
- Load in E (ResultSrcE=01, RdE=7), Rs2D=7 → one cycle of StallF=StallD=FlushE=1; next cycle all 0; StallCount=1.
- Load-use and PCSrcE=1 in the same cycle → FlushD=FlushE=1, StallF=StallD=0.
- MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 → StallF..M and FlushW high for 3 cycles and low on the 4th; state back to RUN; StallCount=3.
- MEM_TIMEOUT=4, MemReadyM held 0 → 4 stalled cycles, then MemErr=1 and stalls stay high; rst_n pulse → MemErr=0, state RUN.
- Without HAZARD_FWD_EN: RdE=3, RegWriteE=1, Rs1D=3 → StallF=StallD=FlushE=1 and Forward*=00; Rs1D=0 with RdE=0 → no stall.
